// File: rtl/saber_loader_pkg.sv
// Shared definitions for the Saber register-bus to BRAM loader.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package saber_loader_pkg;

  // Register word indices on the 32-bit register bus.
  localparam logic [1:0] REG_PTR    = 2'd0;
  localparam logic [1:0] REG_WDATA  = 2'd1;
  localparam logic [1:0] REG_RDATA  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Bit positions inside the STATUS word.
  localparam int STAT_WHALF_BIT = 0;
  localparam int STAT_RHALF_BIT = 1;
  localparam int STAT_ERR_BIT   = 2;
  localparam int STAT_WCNT_LSB  = 16;
  localparam int WCNT_W         = 16;

  // Flag positions inside the PTR read-back word; ptr sits in the low bits.
  localparam int PTR_WHALF_BIT = 31;
  localparam int PTR_RHALF_BIT = 30;

  // Read FSM: a BRAM fetch walks IDLE -> RD -> WAIT -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_e;

  // Packs the STATUS register word from its fields.
  function automatic logic [31:0] pack_status(
    input logic [WCNT_W-1:0] wr_count,
    input logic              err,
    input logic              rhalf,
    input logic              whalf
  );
    logic [31:0] w;
    w = '0;
    w[STAT_WCNT_LSB +: WCNT_W] = wr_count;
    w[STAT_ERR_BIT]            = err;
    w[STAT_RHALF_BIT]          = rhalf;
    w[STAT_WHALF_BIT]          = whalf;
    return w;
  endfunction

endpackage

// File: rtl/saber_mem_loader.sv
// Bridges 32-bit register accesses to 64-bit BRAM words through an auto-incrementing pointer.
// Latency: writes reach the BRAM 1 cycle after the strobe; plain reads answer in 1 cycle, BRAM fetches in 3.
// Backpressure: none; strobes arriving while a fetch is outstanding (busy) are dropped and flag a sticky err.
module saber_mem_loader
  import saber_loader_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int MEM_DW = 64
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              reg_wr_en,
  input  logic [1:0]        reg_wr_addr,
  input  logic [31:0]       reg_wr_data,
  input  logic              reg_rd_en,
  input  logic [1:0]        reg_rd_addr,
  output logic [31:0]       reg_rd_data,
  output logic              reg_rd_valid,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic [MEM_DW-1:0] mem_rdata
);

  localparam logic [MEM_AW-1:0] PTR_ONE  = MEM_AW'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  // Architectural state.
  logic [MEM_AW-1:0] r_ptr;
  logic              r_whalf;
  logic              r_rhalf;
  logic [WCNT_W-1:0] r_wr_count;
  logic              r_err;
  logic [31:0]       r_staged;
  // The low half of a fetched word is returned straight away, so only the
  // high half has to be held for the following RDATA read.
  logic [31:0]       r_latch_hi;
  rd_state_e         r_state;

  // Registered outputs.
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [MEM_DW-1:0] r_mem_wdata;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;

  // Strobe qualification.
  logic              w_any_strobe;
  logic              w_drop;
  logic              w_collide;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_fetch;
  logic [31:0]       w_ptr_word;
  logic [31:0]       w_status_word;
  logic [31:0]       w_rd_mux;

  assign w_any_strobe = reg_wr_en | reg_rd_en;
  // Anything arriving while a fetch is in flight is lost.
  assign w_drop       = w_any_strobe & r_busy;
  // Write wins a same-cycle write/read pair; the read is lost.
  assign w_collide    = reg_wr_en & reg_rd_en & ~r_busy;
  assign w_wr_acc     = reg_wr_en & ~r_busy;
  assign w_rd_acc     = reg_rd_en & ~reg_wr_en & ~r_busy;
  // Only the low-half RDATA read touches the BRAM.
  assign w_fetch      = w_rd_acc & (reg_rd_addr == REG_RDATA) & ~r_rhalf;

  // Build the PTR and STATUS read-back words.
  always_comb begin
    w_ptr_word                = '0;
    w_ptr_word[PTR_WHALF_BIT] = r_whalf;
    w_ptr_word[PTR_RHALF_BIT] = r_rhalf;
    w_ptr_word[MEM_AW-1:0]    = r_ptr;
    w_status_word             = pack_status(r_wr_count, r_err, r_rhalf, r_whalf);
  end

  // Select data for reads answered without a BRAM access.
  always_comb begin
    w_rd_mux = '0;
    case (reg_rd_addr)
      REG_PTR:    w_rd_mux = w_ptr_word;
      REG_WDATA:  w_rd_mux = '0;
      REG_RDATA:  w_rd_mux = r_latch_hi;
      REG_STATUS: w_rd_mux = w_status_word;
      default:    w_rd_mux = '0;
    endcase
  end

  // Register writes, read FSM and every registered output.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_ptr       <= '0;
      r_whalf     <= 1'b0;
      r_rhalf     <= 1'b0;
      r_wr_count  <= '0;
      r_err       <= 1'b0;
      r_staged    <= '0;
      r_latch_hi  <= '0;
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      // Strobes on the BRAM and read-complete sides are single-cycle.
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_rd_valid <= 1'b0;

      if (w_drop || w_collide) begin
        r_err <= 1'b1;
      end

      // Accepted register writes.
      if (w_wr_acc) begin
        case (reg_wr_addr)
          REG_PTR: begin
            r_ptr      <= reg_wr_data[MEM_AW-1:0];
            r_whalf    <= 1'b0;
            r_rhalf    <= 1'b0;
            r_wr_count <= '0;
            // A read colliding with this write still counts as an error.
            r_err      <= w_collide;
          end
          REG_WDATA: begin
            if (!r_whalf) begin
              r_staged <= reg_wr_data;
              r_whalf  <= 1'b1;
            end else begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_ptr;
              r_mem_wdata <= {reg_wr_data, r_staged};
              r_ptr       <= r_ptr + PTR_ONE;
              r_whalf     <= 1'b0;
              if (r_wr_count != WCNT_MAX) begin
                r_wr_count <= r_wr_count + WCNT_W'(1);
              end
            end
          end
          default: ;  // RDATA and STATUS are read-only
        endcase
      end

      // Read path; only IDLE can accept a read since busy covers RD/WAIT.
      case (r_state)
        ST_IDLE: begin
          if (w_fetch) begin
            r_mem_en   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_ptr;
            r_busy     <= 1'b1;
            r_state    <= ST_RD;
          end else if (w_rd_acc) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_rd_mux;
            // High-half RDATA read completes the word and advances.
            if (reg_rd_addr == REG_RDATA) begin
              r_ptr   <= r_ptr + PTR_ONE;
              r_rhalf <= 1'b0;
            end
          end
        end
        ST_RD: begin
          // BRAM is producing the word this cycle.
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_latch_hi <= mem_rdata[MEM_DW-1:32];
          r_rd_data  <= mem_rdata[31:0];
          r_rd_valid <= 1'b1;
          r_rhalf    <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign reg_rd_data  = r_rd_data;
  assign reg_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_saber_mem_loader.sv
// Self-checking bench for saber_mem_loader with a 1-cycle-latency BRAM model.
// Latency: checks 1-cycle writes/plain reads and 3-cycle fetches against a reference model.
// Backpressure: exercises dropped strobes during busy and write/read collisions.
module tb_saber_mem_loader;
  import saber_loader_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b0;
  logic          reg_wr_en = 1'b0;
  logic [1:0]    reg_wr_addr = '0;
  logic [31:0]   reg_wr_data = '0;
  logic          reg_rd_en = 1'b0;
  logic [1:0]    reg_rd_addr = '0;
  logic [31:0]   reg_rd_data;
  logic          reg_rd_valid;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 ACLK = ~ACLK;

  saber_mem_loader #(.MEM_AW(AW), .MEM_DW(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural BRAM: synchronous write, read data valid the next cycle.
  bit [63:0] bram [DEPTH];
  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model of the programmer-visible behaviour.
  bit [63:0]     m_mem [DEPTH];
  logic [AW-1:0] m_ptr = '0;
  logic          m_whalf = 1'b0, m_rhalf = 1'b0, m_err = 1'b0;
  logic [15:0]   m_wcnt = '0;
  logic [31:0]   m_staged = '0;
  logic [63:0]   m_latch = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Hold the given strobes for one cycle; returns #1 after the sampling edge.
  task automatic drive(input bit we, input logic [1:0] wa, input logic [31:0] wd,
                       input bit re, input logic [1:0] ra);
    reg_wr_en   = we;
    reg_wr_addr = wa;
    reg_wr_data = wd;
    reg_rd_en   = re;
    reg_rd_addr = ra;
    tick();
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
  endtask

  function automatic void m_reset();
    m_ptr = '0; m_whalf = 0; m_rhalf = 0; m_err = 0;
    m_wcnt = '0; m_staged = '0; m_latch = '0;
  endfunction

  function automatic void m_wr(input logic [1:0] idx, input logic [31:0] d,
                               output bit w, output logic [AW-1:0] a, output logic [63:0] wd);
    w = 0; a = '0; wd = '0;
    if (idx == REG_PTR) begin
      m_ptr = d[AW-1:0]; m_whalf = 0; m_rhalf = 0; m_wcnt = '0; m_err = 0;
    end else if (idx == REG_WDATA) begin
      if (!m_whalf) begin
        m_staged = d; m_whalf = 1;
      end else begin
        w = 1; a = m_ptr; wd = {d, m_staged};
        m_mem[m_ptr] = wd;
        m_ptr = m_ptr + 1'b1;
        m_whalf = 0;
        if (m_wcnt != 16'hFFFF) m_wcnt = m_wcnt + 1'b1;
      end
    end
  endfunction

  function automatic void m_rd(input logic [1:0] idx, output bit fetch,
                               output logic [31:0] e, output logic [AW-1:0] a);
    fetch = 0; e = '0; a = m_ptr;
    case (idx)
      REG_PTR:   e = {m_whalf, m_rhalf, 20'b0, m_ptr};
      REG_WDATA: e = '0;
      REG_RDATA: begin
        if (!m_rhalf) begin
          fetch = 1; m_latch = m_mem[m_ptr]; e = m_latch[31:0]; m_rhalf = 1;
        end else begin
          e = m_latch[63:32]; m_ptr = m_ptr + 1'b1; m_rhalf = 0;
        end
      end
      default:   e = {m_wcnt, 13'b0, m_err, m_rhalf, m_whalf};
    endcase
  endfunction

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d, input string tag);
    bit w; logic [AW-1:0] a; logic [63:0] wd;
    m_wr(idx, d, w, a, wd);
    drive(1, idx, d, 0, 2'd0);
    chk({tag, "_mem_en"}, mem_en, w);
    chk({tag, "_mem_we"}, mem_we, w);
    if (w) begin
      chk({tag, "_addr"}, mem_addr, a);
      chk({tag, "_wdata"}, mem_wdata, wd);
    end
  endtask

  task automatic rd_reg(input logic [1:0] idx, input string tag);
    bit f; logic [31:0] e; logic [AW-1:0] a;
    m_rd(idx, f, e, a);
    drive(0, 2'd0, 32'd0, 1, idx);
    if (!f) begin
      chk({tag, "_valid1"}, reg_rd_valid, 1);
      chk({tag, "_data"}, reg_rd_data, e);
      chk({tag, "_noacc"}, mem_en, 0);
    end else begin
      chk({tag, "_t1_busy"}, busy, 1);
      chk({tag, "_t1_en"}, mem_en, 1);
      chk({tag, "_t1_we"}, mem_we, 0);
      chk({tag, "_t1_addr"}, mem_addr, a);
      chk({tag, "_t1_valid"}, reg_rd_valid, 0);
      tick();
      chk({tag, "_t2_busy"}, busy, 1);
      chk({tag, "_t2_valid"}, reg_rd_valid, 0);
      tick();
      chk({tag, "_t3_valid"}, reg_rd_valid, 1);
      chk({tag, "_t3_busy"}, busy, 0);
      chk({tag, "_t3_data"}, reg_rd_data, e);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_data"}, reg_rd_data, 0);
    chk({tag, "_rd_valid"}, reg_rd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    bit f; bit w; logic [31:0] e; logic [AW-1:0] a; logic [63:0] wd;
    int base; int n; logic [31:0] d;

    // Reset.
    #1 ARESET = 1'b1;
    #2 chk_outputs_zero("rst_in");
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    tick();
    chk_outputs_zero("rst_out");
    rd_reg(REG_STATUS, "rst_status");

    // Load two words and check the STATUS count.
    wr_reg(REG_PTR, 32'd0, "ld_ptr");
    wr_reg(REG_WDATA, 32'd1, "ld_w1");
    wr_reg(REG_WDATA, 32'd2, "ld_w2");
    wr_reg(REG_WDATA, 32'd3, "ld_w3");
    wr_reg(REG_WDATA, 32'd4, "ld_w4");
    drive(0, 2'd0, 32'd0, 1, REG_STATUS);
    chk("ld_status_const", reg_rd_data, 32'h0002_0000);
    void'(m_rd(REG_STATUS, f, e, a));
    rd_reg(REG_WDATA, "wdata_reads0");

    // Dump them back.
    wr_reg(REG_PTR, 32'd0, "dump_ptr");
    for (int k = 0; k < 4; k++) rd_reg(REG_RDATA, $sformatf("dump%0d", k));
    rd_reg(REG_PTR, "dump_ptr_rb");

    // Pointer wrap at the top of the buffer.
    wr_reg(REG_PTR, DEPTH - 1, "wrap_ptr");
    for (int k = 0; k < 4; k++) wr_reg(REG_WDATA, $urandom, $sformatf("wrap_w%0d", k));
    rd_reg(REG_PTR, "wrap_ptr_rb");
    wr_reg(REG_PTR, DEPTH - 1, "wrap_ptr2");
    for (int k = 0; k < 4; k++) rd_reg(REG_RDATA, $sformatf("wrap_r%0d", k));

    // Read strobe while a fetch is outstanding is dropped.
    wr_reg(REG_PTR, 32'd0, "busy_ptr");
    m_rd(REG_RDATA, f, e, a);
    drive(0, 2'd0, 32'd0, 1, REG_RDATA);
    chk("busy_t1", busy, 1);
    drive(0, 2'd0, 32'd0, 1, REG_STATUS);
    m_err = 1'b1;
    chk("busy_drop_valid", reg_rd_valid, 0);
    // Write strobe during busy is also dropped.
    drive(1, REG_WDATA, 32'hDEAD_BEEF, 0, 2'd0);
    chk("busy_fetch_valid", reg_rd_valid, 1);
    chk("busy_fetch_data", reg_rd_data, e);
    chk("busy_drop_wr_en", mem_en, 0);
    rd_reg(REG_STATUS, "busy_status");
    rd_reg(REG_RDATA, "busy_hi");

    // Same-cycle write and read: write lands, read lost.
    wr_reg(REG_PTR, 32'd0, "col_ptr");
    d = $urandom;
    m_wr(REG_WDATA, d, w, a, wd);
    m_err = 1'b1;
    drive(1, REG_WDATA, d, 1, REG_STATUS);
    chk("col_valid", reg_rd_valid, 0);
    chk("col_mem_en", mem_en, 0);
    rd_reg(REG_STATUS, "col_status");
    wr_reg(REG_WDATA, $urandom, "col_w2");

    // PTR write discards a staged low half.
    wr_reg(REG_WDATA, 32'hAAAA_0001, "stale_w0");
    wr_reg(REG_PTR, 32'd5, "stale_ptr");
    rd_reg(REG_STATUS, "stale_status");
    wr_reg(REG_WDATA, 32'h1111_2222, "stale_w1");
    wr_reg(REG_WDATA, 32'h3333_4444, "stale_w2");
    chk("stale_word_const", mem_wdata, 64'h3333_4444_1111_2222);

    // Randomised load/dump bursts.
    for (int it = 0; it < 10; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 5);
      d    = ($urandom & ~32'(DEPTH - 1)) | 32'(base);
      wr_reg(REG_PTR, d, "rnd_ptr");
      for (int k = 0; k < 2 * n; k++) wr_reg(REG_WDATA, $urandom, "rnd_w");
      if ($urandom_range(0, 1) == 1) rd_reg(REG_STATUS, "rnd_status");
      wr_reg(REG_PTR, 32'(base), "rnd_ptr2");
      for (int k = 0; k < 2 * n; k++) rd_reg(REG_RDATA, "rnd_r");
      rd_reg(REG_PTR, "rnd_ptr_rb");
    end

    // Reset in the middle of a fetch.
    wr_reg(REG_PTR, 32'd7, "mid_ptr");
    drive(0, 2'd0, 32'd0, 1, REG_RDATA);
    tick();
    ARESET = 1'b1;
    #1 chk_outputs_zero("mid_rst");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_valid", reg_rd_valid, 0);
    end
    ARESET = 1'b0;
    m_reset();
    tick();
    chk_outputs_zero("mid_after");
    rd_reg(REG_PTR, "mid_ptr_rb");
    rd_reg(REG_STATUS, "mid_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
